// File: rtl/pixel_pkg.sv
// Shared types and constants for the WS2812-class pixel stream driver.
package pixel_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch
    } state_e;

    // WS2812 timing at a 16 MHz clock, in clk cycles.
    localparam int unsigned WsT0H    = 6;
    localparam int unsigned WsT1H    = 13;
    localparam int unsigned WsTbit   = 20;
    localparam int unsigned WsTreset = 800;

    // Pixel widths for the common strip flavours.
    localparam int unsigned PixRgb  = 24;
    localparam int unsigned PixRgbw = 32;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_stream_driver_if.sv
// Ready/valid pixel stream from the pixel source into the driver.
interface pixel_stream_driver_if #(
    parameter int unsigned PIX_BITS = 24
) ();

    logic [PIX_BITS-1:0] pix_data;
    logic                pix_last;
    logic                pix_valid;
    logic                pix_ready;

    modport master (
        output pix_data,
        output pix_last,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_last,
        input  pix_valid,
        output pix_ready
    );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rdata_o while not empty.
module pixel_fifo
    import pixel_pkg::*;
#(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int unsigned PtrW = cnt_width(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [LvlW-1:0]  level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LvlW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Overflowing pushes and underflowing pops are ignored.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array; no reset so it maps onto plain registers or RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + LvlW'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LvlW'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_stream_driver.sv
// WS2812-class serial LED driver: pixel FIFO feeding a PWM bit serializer with auto-latch.
module pixel_stream_driver
    import pixel_pkg::*;
#(
    parameter int unsigned PIX_BITS   = PixRgb,
    parameter int unsigned T0H        = WsT0H,
    parameter int unsigned T1H        = WsT1H,
    parameter int unsigned TBIT       = WsTbit,
    parameter int unsigned TRESET     = WsTreset,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    pixel_stream_driver_if.slave              pix_if,
    output logic                              data_out,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              underrun,
    output logic                              frame_done
);

    localparam int unsigned TickW = cnt_width(TBIT);
    localparam int unsigned BitW  = cnt_width(PIX_BITS);
    localparam int unsigned LatW  = cnt_width(TRESET);

    localparam logic [TickW-1:0] TickLast = TickW'(TBIT - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(PIX_BITS - 1);
    localparam logic [LatW-1:0]  LatLast  = LatW'(TRESET - 1);

    if (!(T0H >= 1 && T0H < T1H && T1H < TBIT)) begin : g_bad_timing
        $fatal(1, "pixel_stream_driver: need 1 <= T0H < T1H < TBIT");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "pixel_stream_driver: FIFO_DEPTH must be a power of 2, at least 2");
    end

    state_e              state_q;
    logic [TickW-1:0]    tick_q;
    logic [BitW-1:0]     bit_cnt_q;
    logic [LatW-1:0]     latch_cnt_q;
    logic [PIX_BITS-1:0] shreg_q;
    logic                cur_last_q;
    logic                data_out_q;
    logic                busy_q;
    logic                underrun_q;
    logic                frame_done_q;

    logic [PIX_BITS:0]   fifo_head;
    logic [PIX_BITS-1:0] head_data;
    logic                head_last;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                tick_last;
    logic [TickW-1:0]    tick_nxt;
    logic [TickW-1:0]    high_len;

    pixel_fifo #(
        .WIDTH (PIX_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (pix_if.pix_valid),
        .wdata_i ({pix_if.pix_last, pix_if.pix_data}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Ready follows registered occupancy only, so it never depends on a same-cycle pop.
    assign pix_if.pix_ready = !fifo_full;

    assign head_last  = fifo_head[PIX_BITS];
    assign head_data  = fifo_head[PIX_BITS-1:0];
    assign tick_last  = (tick_q == TickLast);
    assign tick_nxt   = tick_q + TickW'(1);
    assign high_len   = shreg_q[PIX_BITS-1] ? TickW'(T1H) : TickW'(T0H);

    assign data_out   = data_out_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;
    assign frame_done = frame_done_q;

    // Pop the FIFO head when idle, or at the end of a non-last pixel to chain without a gap.
    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            StIdle:  pop = !fifo_empty;
            StShift: pop = tick_last && (bit_cnt_q == '0) && !cur_last_q && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    // Serializer FSM; data_out is computed for the tick about to start so it stays registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            tick_q       <= '0;
            bit_cnt_q    <= '0;
            latch_cnt_q  <= '0;
            shreg_q      <= '0;
            cur_last_q   <= 1'b0;
            data_out_q   <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        shreg_q    <= head_data;
                        cur_last_q <= head_last;
                        bit_cnt_q  <= BitLast;
                        tick_q     <= '0;
                        data_out_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= StShift;
                    end else begin
                        data_out_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                StShift: begin
                    if (!tick_last) begin
                        tick_q     <= tick_nxt;
                        data_out_q <= (tick_nxt < high_len);
                    end else begin
                        tick_q <= '0;
                        if (bit_cnt_q != '0) begin
                            shreg_q    <= {shreg_q[PIX_BITS-2:0], 1'b0};
                            bit_cnt_q  <= bit_cnt_q - BitW'(1);
                            data_out_q <= 1'b1;
                        end else if (cur_last_q) begin
                            latch_cnt_q <= '0;
                            data_out_q  <= 1'b0;
                            state_q     <= StLatch;
                        end else if (!fifo_empty) begin
                            shreg_q    <= head_data;
                            cur_last_q <= head_last;
                            bit_cnt_q  <= BitLast;
                            data_out_q <= 1'b1;
                        end else begin
                            underrun_q <= 1'b1;
                            data_out_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= StIdle;
                        end
                    end
                end
                StLatch: begin
                    data_out_q <= 1'b0;
                    if (latch_cnt_q == LatLast) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end else begin
                        latch_cnt_q <= latch_cnt_q + LatW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_driver.sv
// Self-checking bench: line decoder plus pixel scoreboard for the driver.
module tb_pixel_stream_driver;

    localparam int T0H = 6;
    localparam int T1H = 13;
    localparam int TBIT = 20;
    localparam int TRESET = 800;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // 24-bit device under test
    pixel_stream_driver_if #(.PIX_BITS(24)) u_if ();
    logic       data_out, busy, underrun, frame_done;
    logic [4:0] fifo_level;

    pixel_stream_driver u_dut (
        .clk        (clk),
        .reset      (reset),
        .pix_if     (u_if),
        .data_out   (data_out),
        .busy       (busy),
        .fifo_level (fifo_level),
        .underrun   (underrun),
        .frame_done (frame_done)
    );

    // 32-bit (RGBW) device under test
    pixel_stream_driver_if #(.PIX_BITS(32)) u_if32 ();
    logic       d32_out, busy32, ur32, fd32;
    logic [4:0] lvl32;

    pixel_stream_driver #(.PIX_BITS(32)) u_dut32 (
        .clk        (clk),
        .reset      (reset),
        .pix_if     (u_if32),
        .data_out   (d32_out),
        .busy       (busy32),
        .fifo_level (lvl32),
        .underrun   (ur32),
        .frame_done (fd32)
    );

    // Scoreboard of pixels accepted by the 24-bit DUT, in order.
    logic [23:0] sb[$];

    // Line decoder state for the 24-bit DUT.
    logic        m_prev = 1'b0;
    int          m_hi = 0;
    int          m_low = 1000;
    int          m_idx = 0;
    logic [23:0] m_acc = '0;
    int          rise_cnt = 0;
    int          burst_cyc = 0;
    int          pix_done = 0;
    int          ur_cnt = 0;
    int          ur_cyc = 0;
    int          fd_cnt = 0;
    int          fd_cyc = 0;

    // Decode each high pulse into a bit and compare completed pixels against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            m_prev = 1'b0;
            m_hi   = 0;
            m_low  = 1000;
            m_idx  = 0;
            m_acc  = '0;
        end else begin
            if (data_out && !m_prev) begin
                rise_cnt++;
                if (m_low >= TBIT) burst_cyc = cyc;
                m_hi = 1;
            end else if (data_out) begin
                m_hi++;
            end else if (m_prev) begin
                m_low = 0;
                if (sb.size() == 0) begin
                    check("sb_has_pixel", 0, 1);
                end else begin
                    check("bit_width", m_hi, sb[0][23-m_idx] ? T1H : T0H);
                    m_acc = {m_acc[22:0], (m_hi == T1H)};
                    m_idx++;
                    if (m_idx == 24) begin
                        check("pixel", m_acc, sb[0]);
                        void'(sb.pop_front());
                        pix_done++;
                        m_idx = 0;
                    end
                end
            end
            if (!data_out) m_low++;
            if (underrun) begin
                ur_cnt++;
                ur_cyc = cyc;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            m_prev = data_out;
        end
    end

    // Pulse-width capture for the 32-bit DUT.
    logic p32_prev = 1'b0;
    int   w32[32];
    int   w32_n = 0;
    int   w32_hi = 0;
    int   r32_start = 0;
    int   r32_cnt = 0;
    int   fd32_cnt = 0;
    int   fd32_cyc = 0;

    // Record each high width of the RGBW DUT.
    always @(negedge clk) begin
        if (!reset) begin
            if (d32_out && !p32_prev) begin
                if (r32_cnt == 0) r32_start = cyc;
                r32_cnt++;
                w32_hi = 1;
            end else if (d32_out) begin
                w32_hi++;
            end else if (p32_prev && w32_n < 32) begin
                w32[w32_n] = w32_hi;
                w32_n++;
            end
            if (fd32) begin
                fd32_cnt++;
                fd32_cyc = cyc;
            end
            p32_prev = d32_out;
        end
    end

    // Present one pixel and hold valid until accepted; valid is left high for the caller.
    task automatic push(input logic [23:0] d, input logic l);
        int n = 0;
        u_if.pix_valid = 1'b1;
        u_if.pix_data  = d;
        u_if.pix_last  = l;
        while (!u_if.pix_ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!u_if.pix_ready) begin
            check("push_accept", 0, 1);
        end else begin
            @(posedge clk);
            sb.push_back(d);
            #1;
        end
    endtask

    task automatic wait_fd(input int base, input int budget);
        int n = 0;
        while (fd_cnt == base && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frame_done_seen", fd_cnt != base, 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int b_rise, b_fd, b_ur, b_pix;
        int d;

        u_if.pix_valid   = 1'b0;
        u_if.pix_data    = '0;
        u_if.pix_last    = 1'b0;
        u_if32.pix_valid = 1'b0;
        u_if32.pix_data  = '0;
        u_if32.pix_last  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", u_if.pix_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_underrun", underrun, 0);
        check("rst_frame_done", frame_done, 0);
        reset = 1'b0;
        idle_cycles(2);

        // Single last-tagged pixel: latency, bit widths, latch length, frame_done
        b_rise = rise_cnt; b_fd = fd_cnt; b_ur = ur_cnt;
        u_if.pix_valid = 1'b1;
        u_if.pix_data  = 24'hA50000;
        u_if.pix_last  = 1'b1;
        @(posedge clk);
        sb.push_back(24'hA50000);
        #1;
        u_if.pix_valid = 1'b0;
        check("lat_level_n1", fifo_level, 1);
        check("lat_low_n1", data_out, 0);
        @(posedge clk);
        #1;
        check("lat_high_n2", data_out, 1);
        check("lat_busy_n2", busy, 1);
        check("lat_level_n2", fifo_level, 0);
        c = cyc;
        wait_fd(b_fd, 2000);
        check("p1_fd_time", fd_cyc - c, 24 * TBIT + TRESET);
        check("p1_rises", rise_cnt - b_rise, 24);
        check("p1_fd_count", fd_cnt - b_fd, 1);
        check("p1_no_underrun", ur_cnt - b_ur, 0);
        idle_cycles(3);
        check("p1_busy_after", busy, 0);

        // Three back-to-back pixels, last one tagged: 72 contiguous bit periods
        b_rise = rise_cnt; b_fd = fd_cnt; b_ur = ur_cnt;
        push(24'h123456, 1'b0);
        push(24'hFEDCBA, 1'b0);
        push(24'h00FF01, 1'b1);
        u_if.pix_valid = 1'b0;
        wait_fd(b_fd, 4000);
        check("p3_fd_time", fd_cyc - burst_cyc, 72 * TBIT + TRESET);
        check("p3_rises", rise_cnt - b_rise, 72);
        check("p3_fd_count", fd_cnt - b_fd, 1);
        check("p3_no_underrun", ur_cnt - b_ur, 0);
        check("p3_sb_drained", sb.size(), 0);
        idle_cycles(3);

        // Two untagged pixels then starve: underrun, no latch, line stays low
        b_rise = rise_cnt; b_fd = fd_cnt; b_ur = ur_cnt; b_pix = pix_done;
        push(24'hC3C3C3, 1'b0);
        push(24'h0F0F0F, 1'b0);
        u_if.pix_valid = 1'b0;
        begin
            int n = 0;
            while (ur_cnt == b_ur && n < 1500) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("ur_seen", ur_cnt - b_ur, 1);
        // Registered pulse: on the final tick or the cycle right after it.
        d = ur_cyc - burst_cyc;
        check("ur_time", (d == 2 * 24 * TBIT - 1) || (d == 2 * 24 * TBIT), 1);
        idle_cycles(1000);
        check("ur_pixels", pix_done - b_pix, 2);
        check("ur_rises", rise_cnt - b_rise, 48);
        check("ur_line_low", data_out, 0);
        check("ur_busy", busy, 0);
        check("ur_no_fd", fd_cnt - b_fd, 0);
        check("ur_single", ur_cnt - b_ur, 1);

        // 20 pixels with valid held: FIFO fills to 16, then every pixel goes out in order
        b_fd = fd_cnt; b_ur = ur_cnt; b_pix = pix_done;
        for (int i = 0; i < 20; i++) begin
            logic [31:0] v;
            v = (i + 1) * 32'h0019_660D + 32'h3C6E_F35F;
            push(v[23:0], i == 19);
            if (i == 15) begin
                check("fill_level15", fifo_level, 15);
                check("fill_ready15", u_if.pix_ready, 1);
            end
            if (i == 16) begin
                check("fill_level16", fifo_level, 16);
                check("fill_ready16", u_if.pix_ready, 0);
            end
        end
        u_if.pix_valid = 1'b0;
        begin
            int n = 0;
            while (pix_done - b_pix < 20 && n < 12000) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("fill_pixels", pix_done - b_pix, 20);
        wait_fd(b_fd, 2000);
        check("fill_fd_count", fd_cnt - b_fd, 1);
        check("fill_no_underrun", ur_cnt - b_ur, 0);
        check("fill_sb_drained", sb.size(), 0);
        idle_cycles(3);

        // Reset at tick 3 of bit 5 with the line high
        b_rise = rise_cnt; b_fd = fd_cnt; b_ur = ur_cnt;
        push(24'hABCDEF, 1'b0);
        push(24'h123456, 1'b1);
        u_if.pix_valid = 1'b0;
        @(negedge clk);
        c = burst_cyc;
        begin
            int n = 0;
            while (cyc < c + 5 * TBIT + 3 && n < 500) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("mid_pre_high", data_out, 1);
        check("mid_pre_level", fifo_level, 1);
        check("mid_pre_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_data_out", data_out, 0);
        check("mid_level", fifo_level, 0);
        check("mid_busy", busy, 0);
        check("mid_ready", u_if.pix_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        b_rise = rise_cnt;
        idle_cycles(1000);
        check("mid_no_rise", rise_cnt - b_rise, 0);
        check("mid_no_fd", fd_cnt - b_fd, 0);
        check("mid_no_ur", ur_cnt - b_ur, 0);

        // RGBW: 32'h8000_0001 -> first and last bits wide, the rest narrow, then latch
        u_if32.pix_valid = 1'b1;
        u_if32.pix_data  = 32'h8000_0001;
        u_if32.pix_last  = 1'b1;
        @(posedge clk);
        #1;
        u_if32.pix_valid = 1'b0;
        begin
            int n = 0;
            while (fd32_cnt == 0 && n < 3000) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("w32_fd_count", fd32_cnt, 1);
        check("w32_bits", w32_n, 32);
        check("w32_first", w32[0], T1H);
        check("w32_second", w32[1], T0H);
        check("w32_penult", w32[30], T0H);
        check("w32_last", w32[31], T1H);
        check("w32_fd_time", fd32_cyc - r32_start, 32 * TBIT + TRESET);
        check("w32_no_ur", ur32, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pixel_stream_driver.md
Name: pixel_stream_driver

Overview:
Next-generation WS2812-class serial LED driver. A ready/valid pixel stream feeds an internal show-ahead FIFO, and the FIFO feeds a parametrised PWM serializer. Pixels of any width (RGB 24b, RGBW 32b) are sent back-to-back with no inter-pixel gap. A pixel tagged `last` triggers an automatic latch (line low for TRESET ticks), so the block drives a whole strip from a free-running pixel source.

Parameters:
PIX_BITS, 24, bits per pixel, sent MSB first (24 = GRB/RGB, 32 = RGBW)
T0H, 6, clk cycles data_out is high for a 0 bit
T1H, 13, clk cycles data_out is high for a 1 bit
TBIT, 20, clk cycles per bit period
TRESET, 800, clk cycles data_out is held low for latch (50 us at 16 MHz)
FIFO_DEPTH, 16, pixel FIFO entries; power of 2, at least 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_data  in  PIX_BITS  pixel value, MSB transmitted first
pix_last  in  1  latch the strip after this pixel
pix_valid  in  1  pix_data/pix_last valid
pix_ready  out  1  FIFO can accept; equals !full
data_out  out  1  serial line to strip
busy  out  1  high in SHIFT or LATCH
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
underrun  out  1  one-cycle pulse: FIFO empty at the end of a non-last pixel
frame_done  out  1  one-cycle pulse at the end of the latch period

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high.
- Reset values: state IDLE, FIFO empty, data_out=0, busy=0, pix_ready=1, fifo_level=0, underrun=0, frame_done=0.
- Push: accepted when pix_valid && pix_ready. Stores {pix_last, pix_data}. pix_ready depends only on registered occupancy, never combinationally on a pop.
- Simultaneous push and pop: fifo_level is unchanged.
- States:
  - IDLE: if FIFO non-empty, pop the head, load the shift register, set bit_cnt=PIX_BITS-1 and tick=0, go to SHIFT.
  - SHIFT: tick counts 0..TBIT-1. data_out=1 while tick < (cur_bit ? T1H : T0H), else 0.
    - At tick=TBIT-1 with bit_cnt>0: shift left, decrement bit_cnt.
    - At tick=TBIT-1 with bit_cnt=0 and the pixel is last: go to LATCH.
    - At tick=TBIT-1 with bit_cnt=0, not last, FIFO non-empty: pop and reload in the same cycle, stay in SHIFT. The next bit period begins on the following cycle with no gap.
    - At tick=TBIT-1 with bit_cnt=0, not last, FIFO empty: pulse underrun, go to IDLE.
  - LATCH: data_out=0 for TRESET cycles. On the final cycle, pulse frame_done and go to IDLE. Pixels may be pushed during LATCH; they are not popped until IDLE.
- data_out and the pulses are registered outputs.
- Latency: a push into an empty FIFO while IDLE at cycle N gives fifo_level=1 at N+1, pop/load at N+1, and data_out high at N+2.
- Underrun: an idle low line longer than the strip's reset threshold latches the strip implicitly. The block does not suppress this; upstream is responsible for keeping the FIFO fed.
- Reset mid-operation: within one cycle data_out=0, the FIFO is flushed and state is IDLE. The truncated bit is not completed, and no frame_done or underrun pulse is produced.
- Counter widths: tick is $clog2(TBIT) bits; latch counter is $clog2(TRESET) bits; bit_cnt is $clog2(PIX_BITS) bits.
- Elaboration checks: 1 <= T0H < T1H < TBIT, and FIFO_DEPTH is a power of 2. A violation is a fatal error.

Decomposition:
- Shared package pixel_pkg: state enum (IDLE, SHIFT, LATCH), WS2812 default timing constants at 16 MHz (T0H/T1H/TBIT/TRESET), and the pixel-width constants RGB=24 and RGBW=32.
- One sub-module, pixel_fifo: synchronous show-ahead FIFO, width PIX_BITS+1, depth FIFO_DEPTH, with full/empty/level outputs. The serializer FSM lives in the top module.

Test Plan:
- Single pixel 24'hA50000 with last=1 from IDLE -> data_out high at N+2. Bits 1,0,1,0,0,1,0,1 give high widths 13,6,13,6,6,13,6,13 in 20-cycle periods, then 16 zero-bits. After 480 cycles, data_out stays low for 800 cycles, then frame_done pulses once.
- Three pixels pushed back-to-back, the last tagged -> 72 consecutive bit periods with no idle cycle between pixels, one latch, one frame_done, no underrun.
- Two untagged pixels, no further push -> underrun pulses on the last cycle of pixel 2; state returns to IDLE; data_out stays 0; no frame_done.
- Push 20 pixels with pix_valid held high while IDLE, FIFO_DEPTH=16 -> pix_ready drops when fifo_level reaches 16. Pops then free slots, and every pushed pixel is transmitted exactly once, in order.
- Assert reset at tick=3 of bit 5 while data_out is high -> data_out=0 the next cycle, fifo_level=0, busy=0, no pulses.
- PIX_BITS=32, push 32'h8000_0001 with last=1 -> 32 bit periods with the first and last high widths equal to 13, then the latch.
